sha256_padder: RTL
==================

# sha256_padder

Message padder and block feeder for the SHA-256 core. It accepts a message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit message bit-length. It presents complete 16-word blocks on a valid/ready interface shaped to the core's `m_i` array. It also marks the first block (core uses IV) and the last block (final digest) so the core's chaining/`mode` selection can be driven directly.

## Interface
Parameters:
- `n`, 32, word width.
- `m`, 16, words per block.
- `LEN_W`, 64, message bit-length counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, reset is asynchronous and active-high.
- `data_i`  in  n  message word; the first byte is in [31:24].
- `valid_i`  in  1  `data_i` is valid.
- `last_i`  in  1  this word is the final word of the message.
- `bytes_i`  in  2  valid bytes in the final word: 1..3 means that many bytes, 0 means 4 bytes. Ignored unless `last_i`=1.
- `ready_o`  out  1  the padder accepts a word this cycle.
- `blk_o`  out  n x m  unpacked array [0:m-1] of block words.
- `blk_valid_o`  out  1  `blk_o` holds a complete block.
- `blk_first_o`  out  1  the block is the first block of its message.
- `blk_last_o`  out  1  the block is the final block of its message.
- `blk_ready_i`  in  1  the core takes the block.

## Operation
- States:
  - S_FILL: accepts input words.
  - S_PAD: writes padding words, one per cycle, with no input accepted.
  - S_HOLD: the block is presented.
- Word index `idx` runs 0..15. The bit-length counter `len` is LEN_W bits and wraps mod 2^64.
- S_FILL:
  - `ready_o`=1.
  - On `valid_i`: write `data_i` to `blk_o[idx]` and increment `idx`.
  - `len` increases by 32, or by 8*`bytes_i` on a last word with `bytes_i`≠0.
- Last word with `bytes_i`=k≠0:
  - Bytes k..3 are replaced by 0x80 followed by zeros. Input garbage in those bytes is masked.
  - Go to S_PAD.
- Last word with `bytes_i`=0: the word is stored whole and S_PAD writes 0x80000000 as its first pad word.
- S_PAD:
  - Writes zeros until `idx`=14, then writes `len[63:32]` and `len[31:0]` at indices 14 and 15. Then S_HOLD with `blk_last_o`=1.
  - If the 0x80 word lands at index 14 or 15, zero-fill through 15 and go to S_HOLD with `blk_last_o`=0. After the handshake, return to S_PAD with a pending-length flag set: words 0..13 are zeros, words 14..15 are `len`.
- `idx` reaching 16 in S_FILL (no last seen): go to S_HOLD, `blk_last_o`=0.
- S_HOLD:
  - `ready_o`=0.
  - `blk_o`, `blk_first_o` and `blk_last_o` are stable.
  - Transfer on `blk_valid_o` & `blk_ready_i`. Then `idx`=0, buffer cleared to zero, and the next state is one of:
    - S_FILL for a continuing message, or a new message after a last block.
    - S_PAD for a pending length block.
- `blk_first_o` is set for the first block after reset or after a last block. It clears after that block's handshake.
- After a last-block transfer, `len`=0.
- `valid_i` outside S_FILL is ignored; the source must hold the word, since `ready_o`=0.
- Empty (zero-byte) messages are not supported.

## Timing
- Reset values:
  - `ready_o`=1, `blk_valid_o`=0, `blk_first_o`=1, `blk_last_o`=0.
  - `blk_o` all zero, `idx`=0, `len`=0, state S_FILL.
- `blk_valid_o` rises the cycle after the 16th word (data or pad) is registered.
- The pad phase costs (16 - `idx` after the last word) cycles, plus 16 cycles for an extra length block.
- `ready_o` rises the cycle after the S_HOLD handshake. There is one bubble cycle; the handshake cycle and a new input are never accepted together.
- `blk_ready_i` held low keeps S_HOLD indefinitely. There is no timeout.
- Reset mid-operation discards the partial block and `len`. Outputs return to reset values immediately, asynchronously.

## Structure
- Shared package `sha256_pkg`:
  - State enum `pad_state_t`.
  - Constants `BLK_WORDS`=16, `PAD_BYTE`=8'h80, `LEN_IDX_HI`=14, `LEN_IDX_LO`=15.
  - The core's IV and K constants also move there.
- One sub-module, `sha256_pad_word`: combinational masking of the final word given `bytes_i` (data bytes kept, 0x80 inserted, tail zeroed). Everything else lives in `sha256_padder`.

## Test plan
- "abc": `data_i`=0x61626300, `bytes_i`=3, `last_i`=1.
  - Expect one block: w0=0x61626380, w1..w14=0, w15=0x00000018.
  - `blk_first_o`=`blk_last_o`=1.
- 55-byte message: 13 full words plus last word with `bytes_i`=3.
  - Expect one block: w13 = data|0x80 in byte 3, w14=0, w15=0x000001B8.
- 56-byte message: 14 words, last with `bytes_i`=0.
  - Block 0: w14=0x80000000, w15=0, `blk_last_o`=0.
  - Block 1: w0..w14=0, w15=0x000001C0, `blk_first_o`=0, `blk_last_o`=1.
- 64-byte message:
  - Block 0: all data.
  - Block 1: w0=0x80000000, w1..w14=0, w15=0x00000200.
- Backpressure: hold `blk_ready_i`=0 for 5 cycles in S_HOLD while `valid_i`=1.
  - `blk_o` stable, `ready_o`=0, no words lost.
  - After the release the next word is accepted one cycle later.
- Reset pulse after 7 words of a message:
  - All outputs go to reset values the same cycle.
  - A following "abc" message produces the exact block from the first test.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state type, block geometry and padding
// constants, and the core's initial hash value and round constants.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_HOLD
    } pad_state_t;

    localparam int unsigned BLK_WORDS  = 16;
    localparam logic [7:0]  PAD_BYTE   = 8'h80;
    localparam int unsigned LEN_IDX_HI = 14;
    localparam int unsigned LEN_IDX_LO = 15;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word masking: keeps the first bytes_i data bytes, inserts the 0x80
// marker after them and zeroes the tail. bytes_i = 0 passes the word whole.
module sha256_pad_word
    import sha256_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [n-1:0] data_i,
    input  logic [1:0]   bytes_i,
    output logic [n-1:0] word_o
);

    always_comb begin
        word_o = data_i;
        if (bytes_i != 2'd0) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (b == 32'(bytes_i))
                    word_o[n-1-8*b -: 8] = PAD_BYTE;
                else if (b > 32'(bytes_i))
                    word_o[n-1-8*b -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: collects big-endian words into 16-word blocks,
// appends 0x80, zero fill and the 64-bit bit length, and hands blocks to the core.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int n     = 32,
    parameter int m     = BLK_WORDS,
    parameter int LEN_W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [n-1:0] data_i,
    input  logic         valid_i,
    input  logic         last_i,
    input  logic [1:0]   bytes_i,
    output logic         ready_o,
    output logic [n-1:0] blk_o [0:m-1],
    output logic         blk_valid_o,
    output logic         blk_first_o,
    output logic         blk_last_o,
    input  logic         blk_ready_i
);

    localparam int IDX_W = $clog2(m);

    pad_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_inc;
    logic             need_80;
    logic             len_ovf;
    logic             ovf_next;
    logic             at_hi;
    logic             at_lo;
    logic [n-1:0]     last_word;
    logic [n-1:0]     pad_fill;

    sha256_pad_word #(
        .n(n)
    ) u_pad_word (
        .data_i (data_i),
        .bytes_i(bytes_i),
        .word_o (last_word)
    );

    assign at_hi = idx >= IDX_W'(LEN_IDX_HI);
    assign at_lo = idx == IDX_W'(LEN_IDX_LO);

    // need_80: marker still owed (last word was whole); len_ovf: marker landed
    // at index 14/15, so the length moves to an extra block.
    always_comb begin
        len_inc  = (last_i && bytes_i != 2'd0) ? LEN_W'({bytes_i, 3'b000}) : LEN_W'(n);
        ovf_next = len_ovf | (need_80 & at_hi);
        pad_fill = '0;
        if (need_80)
            pad_fill = {PAD_BYTE, {(n-8){1'b0}}};
        else if (!len_ovf && idx == IDX_W'(LEN_IDX_HI))
            pad_fill = len[2*n-1:n];
        else if (!len_ovf && at_lo)
            pad_fill = len[n-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_FILL;
            ready_o     <= 1'b1;
            blk_valid_o <= 1'b0;
            blk_first_o <= 1'b1;
            blk_last_o  <= 1'b0;
            idx         <= '0;
            len         <= '0;
            need_80     <= 1'b0;
            len_ovf     <= 1'b0;
            for (int unsigned i = 0; i < m; i++)
                blk_o[i] <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (valid_i) begin
                        blk_o[idx] <= last_i ? last_word : data_i;
                        idx        <= idx + 1'b1;
                        len        <= len + len_inc;
                        if (last_i) begin
                            need_80 <= (bytes_i == 2'd0);
                            len_ovf <= (bytes_i != 2'd0) && at_hi;
                        end
                        if (at_lo) begin
                            state       <= S_HOLD;
                            ready_o     <= 1'b0;
                            blk_valid_o <= 1'b1;
                            blk_last_o  <= 1'b0;
                        end else if (last_i) begin
                            state   <= S_PAD;
                            ready_o <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    blk_o[idx] <= pad_fill;
                    idx        <= idx + 1'b1;
                    need_80    <= 1'b0;
                    len_ovf    <= ovf_next;
                    if (at_lo) begin
                        state       <= S_HOLD;
                        blk_valid_o <= 1'b1;
                        blk_last_o  <= !ovf_next;
                    end
                end
                S_HOLD: begin
                    if (blk_valid_o && blk_ready_i) begin
                        blk_valid_o <= 1'b0;
                        blk_first_o <= blk_last_o;
                        blk_last_o  <= 1'b0;
                        idx         <= '0;
                        len_ovf     <= 1'b0;
                        for (int unsigned i = 0; i < m; i++)
                            blk_o[i] <= '0;
                        if (blk_last_o) begin
                            len     <= '0;
                            state   <= S_FILL;
                            ready_o <= 1'b1;
                        end else if (len_ovf || need_80) begin
                            state <= S_PAD;
                        end else begin
                            state   <= S_FILL;
                            ready_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_FILL;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
